// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================================
// ahb_pkg : AHB-Lite encodings and register map shared by master, slave, benches
// Revision: 1.0
// ============================================================================
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    NONSEQ = 2'd2,
    SEQ    = 2'd3
  } htrans_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  // Register map of the companion slave register block
  localparam int unsigned ERR_STATUS_ADDRESS = 1;
  localparam int unsigned PAYLOAD_ADDRESS    = 2;
  localparam int unsigned DATA_SIZE_ADDRESS  = 4;

endpackage
`default_nettype wire

// File: rtl/ahb_master_interface.sv
`default_nettype none
// ============================================================================
// ahb_master_interface : single-beat AHB-Lite initiator, in-order responses
// Revision: 1.0
// ============================================================================
module ahb_master_interface
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  hclk,
  input  logic                  hreset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [2:0]            cmd_size,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  hsel_x,
  output logic [ADDR_WIDTH-1:0] haddr,
  output logic [1:0]            htrans,
  output logic                  hwrite,
  output logic [2:0]            hsize,
  output logic [DATA_WIDTH-1:0] hwdata,
  input  logic [DATA_WIDTH-1:0] hrdata,
  input  logic                  hready,
  input  logic                  hresp
);

  logic                  r_a_valid;
  logic [ADDR_WIDTH-1:0] r_a_addr;
  logic                  r_a_write;
  logic [2:0]            r_a_size;
  logic [DATA_WIDTH-1:0] r_a_wdata;
  logic                  r_suspend;
  logic                  r_d_valid;
  logic                  r_d_write;
  logic [DATA_WIDTH-1:0] r_d_wdata;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_err;

  logic w_a_issue;
  logic w_accept;

  assign w_a_issue = r_a_valid & ~r_suspend;
  assign cmd_ready = hreset_n & hready & ~hresp & ~r_suspend;
  assign w_accept  = cmd_valid & cmd_ready;

  assign htrans = w_a_issue ? NONSEQ : IDLE;
  assign haddr  = r_a_valid ? r_a_addr  : '0;
  assign hwrite = r_a_valid ? r_a_write : 1'b0;
  assign hsize  = r_a_valid ? r_a_size  : 3'd0;
  assign hwdata = (r_d_valid & r_d_write) ? r_d_wdata : '0;
  assign hsel_x = r_a_valid | r_d_valid;

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

  always_ff @(posedge hclk) begin
    if (!hreset_n) begin
      r_a_valid   <= 1'b0;
      r_a_addr    <= '0;
      r_a_write   <= 1'b0;
      r_a_size    <= 3'd0;
      r_a_wdata   <= '0;
      r_suspend   <= 1'b0;
      r_d_valid   <= 1'b0;
      r_d_write   <= 1'b0;
      r_d_wdata   <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= r_d_valid & hready;
      if (r_d_valid & hready) begin
        r_rsp_err   <= hresp;
        r_rsp_rdata <= r_d_write ? '0 : hrdata;
      end

      if (hready) begin
        r_suspend <= 1'b0;
        if (r_suspend) begin
          // Second ERROR cycle: the held address phase is re-driven next cycle
          r_d_valid <= 1'b0;
        end else begin
          r_d_valid <= r_a_valid;
          r_d_write <= r_a_write;
          r_d_wdata <= r_a_wdata;
          r_a_valid <= w_accept;
          if (w_accept) begin
            r_a_addr  <= cmd_addr;
            r_a_write <= cmd_write;
            r_a_size  <= cmd_size;
            r_a_wdata <= cmd_wdata;
          end
        end
      end else if (r_d_valid & hresp & w_a_issue) begin
        // First ERROR cycle: cancel the pipelined follower so it goes IDLE
        r_suspend <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ahb_master_interface.sv
`default_nettype none
// ============================================================================
// tb_ahb_master_interface : randomized bench with AHB slave model and
// in-order response scoreboard
// Revision: 1.0
// ============================================================================
module tb_ahb_master_interface;
  import ahb_pkg::*;

  logic       hclk = 1'b0;
  logic       hreset_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_write = 1'b0;
  logic [2:0] cmd_addr = 3'd0;
  logic [2:0] cmd_size = 3'd0;
  logic [7:0] cmd_wdata = 8'd0;
  logic       cmd_ready, rsp_valid, rsp_err, hsel_x, hwrite;
  logic [7:0] rsp_rdata, hwdata;
  logic [2:0] haddr, hsize;
  logic [1:0] htrans;
  logic [7:0] hrdata = 8'd0;
  logic       hready = 1'b1;
  logic       hresp = 1'b0;

  always #5 hclk = ~hclk;

  ahb_master_interface #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) dut (
    .hclk(hclk), .hreset_n(hreset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .hsel_x(hsel_x), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp)
  );

  typedef struct {
    logic       write;
    logic [2:0] addr;
    logic [2:0] size;
    logic [7:0] wdata;
    int         waits;
    logic       err;
  } xfer_t;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
  } rsp_t;

  xfer_t plan_q[$];
  xfer_t force_q[$];
  rsp_t  exp_q[$];
  logic [7:0] smem[8];
  logic [7:0] shadow[8];
  bit    s_active, s_e1, auto_cmd, accepted;
  int    s_cnt;
  xfer_t s_x;
  int    vectors = 0;
  int    miscompares = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic force_plan(input int w, input bit e);
    xfer_t f;
    f.write = 1'b0; f.addr = 3'd0; f.size = 3'd0; f.wdata = 8'd0;
    f.waits = w;
    f.err   = e;
    force_q.push_back(f);
  endtask

  task automatic set_cmd(input bit v, input bit w, input int a, input int d);
    cmd_valid = v;
    cmd_write = w;
    cmd_addr  = 3'(a);
    cmd_wdata = 8'(d);
    cmd_size  = HSIZE_BYTE;
  endtask

  // Slave drives its response for the cycle just started
  task automatic edge_drive();
    @(posedge hclk);
    #1;
    if (!s_active) begin
      hready = 1'b1; hresp = HRESP_OKAY;
    end else if (s_cnt > 0) begin
      hready = 1'b0; hresp = HRESP_OKAY;
    end else if (s_x.err) begin
      hready = s_e1; hresp = HRESP_ERROR;
    end else begin
      hready = 1'b1; hresp = HRESP_OKAY;
    end
    hrdata = (s_active && !s_x.write) ? smem[s_x.addr] : 8'($urandom);
    if (auto_cmd && (!cmd_valid || accepted)) begin
      cmd_valid = ($urandom_range(0, 9) < 7);
      cmd_write = 1'($urandom_range(0, 1));
      cmd_addr  = 3'($urandom);
      cmd_size  = 3'($urandom_range(0, 2));
      cmd_wdata = 8'($urandom);
    end
  endtask

  // Observe the settled cycle and apply the events of the coming edge
  task automatic sample_cycle();
    xfer_t x, f;
    rsp_t  r;
    @(negedge hclk);
    accepted = 1'b0;
    if (!hreset_n) begin
      check_val("ready_in_reset", 32'(cmd_ready), 32'd0);
      s_active = 1'b0;
      s_e1 = 1'b0;
      plan_q.delete();
      exp_q.delete();
      return;
    end
    check_val("htrans_legal", 32'(htrans == IDLE || htrans == NONSEQ), 32'd1);
    if (!hready) check_val("ready_in_wait", 32'(cmd_ready), 32'd0);
    if (rsp_valid) begin
      if (exp_q.size() == 0) check_val("spurious_rsp", 32'(rsp_valid), 32'd0);
      else begin
        r = exp_q.pop_front();
        check_val("rsp_rdata", 32'(rsp_rdata), 32'(r.rdata));
        check_val("rsp_err", 32'(rsp_err), 32'(r.err));
      end
    end
    if (s_active) begin
      if (hready) begin
        if (s_x.write) begin
          check_val("hwdata", 32'(hwdata), 32'(s_x.wdata));
          if (!s_x.err) smem[s_x.addr] = hwdata;
        end
        s_active = 1'b0;
      end else if (s_cnt > 0) s_cnt--;
      else s_e1 = 1'b1;
    end
    if (hready && htrans == NONSEQ) begin
      if (plan_q.size() == 0) check_val("spurious_nonseq", 32'(htrans), 32'(IDLE));
      else begin
        x = plan_q.pop_front();
        check_val("haddr", 32'(haddr), 32'(x.addr));
        check_val("hwrite", 32'(hwrite), 32'(x.write));
        check_val("hsize", 32'(hsize), 32'(x.size));
        s_active = 1'b1; s_x = x; s_cnt = x.waits; s_e1 = 1'b0;
      end
    end
    if (cmd_valid && cmd_ready) begin
      accepted = 1'b1;
      x.write = cmd_write; x.addr = cmd_addr; x.size = cmd_size; x.wdata = cmd_wdata;
      if (force_q.size() > 0) begin
        f = force_q.pop_front();
        x.waits = f.waits; x.err = f.err;
      end else begin
        x.waits = $urandom_range(0, 2);
        x.err = ($urandom_range(0, 5) == 0);
      end
      plan_q.push_back(x);
      r.err   = x.err;
      r.rdata = x.write ? 8'h00 : shadow[x.addr];
      if (x.write && !x.err) shadow[x.addr] = x.wdata;
      exp_q.push_back(r);
    end
  endtask

  task automatic step();
    edge_drive();
    sample_cycle();
  endtask

  task automatic check_reset_outputs();
    check_val("rst_htrans", 32'(htrans), 32'd0);
    check_val("rst_hsel", 32'(hsel_x), 32'd0);
    check_val("rst_haddr", 32'(haddr), 32'd0);
    check_val("rst_hwrite", 32'(hwrite), 32'd0);
    check_val("rst_hsize", 32'(hsize), 32'd0);
    check_val("rst_hwdata", 32'(hwdata), 32'd0);
    check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_val("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check_val("rst_rsp_err", 32'(rsp_err), 32'd0);
    check_val("rst_cmd_ready", 32'(cmd_ready), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 8; i++) begin
      smem[i] = 8'($urandom);
      shadow[i] = smem[i];
    end
    auto_cmd = 1'b0;
    repeat (3) step();
    check_reset_outputs();

    // Single write, zero wait
    force_plan(0, 1'b0);
    edge_drive(); hreset_n = 1'b1; set_cmd(1, 1, 4, 8'd12); sample_cycle();
    check_val("t1_accept", 32'(cmd_ready), 32'd1);
    edge_drive(); set_cmd(0, 0, 0, 0); sample_cycle();
    check_val("t1_htrans", 32'(htrans), 32'(NONSEQ));
    check_val("t1_haddr", 32'(haddr), 32'd4);
    check_val("t1_hsel", 32'(hsel_x), 32'd1);
    step();
    check_val("t1_idle", 32'(htrans), 32'(IDLE));
    check_val("t1_hwdata", 32'(hwdata), 32'd12);
    check_val("t1_early_rsp", 32'(rsp_valid), 32'd0);
    step();
    check_val("t1_rsp", 32'(rsp_valid), 32'd1);

    // Back-to-back write then read
    force_plan(0, 1'b0); force_plan(0, 1'b0);
    edge_drive(); set_cmd(1, 1, 2, 8'h29); sample_cycle();
    edge_drive(); set_cmd(1, 0, 4, 0); sample_cycle();
    check_val("t2_accept2", 32'(cmd_ready), 32'd1);
    edge_drive(); set_cmd(0, 0, 0, 0); sample_cycle();
    check_val("t2_overlap_haddr", 32'(haddr), 32'd4);
    check_val("t2_overlap_hwdata", 32'(hwdata), 32'h29);
    step();
    check_val("t2_rsp_w", 32'(rsp_valid), 32'd1);
    step();
    check_val("t2_rsp_r", 32'(rsp_valid), 32'd1);
    check_val("t2_rdata", 32'(rsp_rdata), 32'd12);

    // Two wait states with a pipelined follower
    force_plan(2, 1'b0); force_plan(0, 1'b0);
    edge_drive(); set_cmd(1, 1, 3, 8'h0D); sample_cycle();
    edge_drive(); set_cmd(1, 0, 2, 0); sample_cycle();
    for (int k = 0; k < 2; k++) begin
      edge_drive(); set_cmd(0, 0, 0, 0); sample_cycle();
      check_val("t3_hwdata_hold", 32'(hwdata), 32'h0D);
      check_val("t3_htrans_hold", 32'(htrans), 32'(NONSEQ));
      check_val("t3_haddr_hold", 32'(haddr), 32'd2);
      check_val("t3_ready_low", 32'(cmd_ready), 32'd0);
    end
    step();
    check_val("t3_rsp_late", 32'(rsp_valid), 32'd0);
    step();
    check_val("t3_rsp", 32'(rsp_valid), 32'd1);
    repeat (2) step();

    // ERROR on a write with a read in its address phase
    force_plan(0, 1'b1); force_plan(0, 1'b0);
    edge_drive(); set_cmd(1, 1, 1, 8'h5A); sample_cycle();
    edge_drive(); set_cmd(1, 0, 4, 0); sample_cycle();
    edge_drive(); set_cmd(0, 0, 0, 0); sample_cycle();
    check_val("t4_err1_hresp_seen", 32'(htrans), 32'(NONSEQ));
    step();
    check_val("t4_err2_idle", 32'(htrans), 32'(IDLE));
    check_val("t4_err2_hsel", 32'(hsel_x), 32'd1);
    step();
    check_val("t4_rsp_err", 32'(rsp_err), 32'd1);
    check_val("t4_retry_htrans", 32'(htrans), 32'(NONSEQ));
    check_val("t4_retry_haddr", 32'(haddr), 32'd4);
    repeat (3) step();

    // Idle bus
    for (int k = 0; k < 5; k++) begin
      step();
      check_val("t5_htrans", 32'(htrans), 32'(IDLE));
      check_val("t5_hsel", 32'(hsel_x), 32'd0);
      check_val("t5_rsp", 32'(rsp_valid), 32'd0);
    end

    // Reset during a stalled read data phase
    force_plan(3, 1'b0);
    edge_drive(); set_cmd(1, 0, 4, 0); sample_cycle();
    edge_drive(); set_cmd(0, 0, 0, 0); sample_cycle();
    edge_drive(); hreset_n = 1'b0; sample_cycle();
    step();
    check_reset_outputs();
    edge_drive(); hreset_n = 1'b1; sample_cycle();
    repeat (4) step();
    force_plan(0, 1'b0);
    edge_drive(); set_cmd(1, 0, 4, 0); sample_cycle();
    edge_drive(); set_cmd(0, 0, 0, 0); sample_cycle();
    repeat (2) step();
    check_val("t6_after_reset_rsp", 32'(rsp_valid), 32'd1);
    check_val("t6_after_reset_rdata", 32'(rsp_rdata), 32'd12);

    // Randomized traffic
    auto_cmd = 1'b1;
    repeat (400) step();
    auto_cmd = 1'b0;
    edge_drive(); set_cmd(0, 0, 0, 0); sample_cycle();
    for (int n = 0; n < 60 && (exp_q.size() > 0 || s_active); n++) step();
    check_val("drain_pending", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
